// File: rtl/op_logic_seq_pkg.sv
// Shared definitions for the sequential logical-operation unit:
// opcode and shift-type encodings, FSM states, and opcode helpers.
package op_logic_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'd0,
        OP_ORR = 3'd1,
        OP_EOR = 3'd2,
        OP_BIC = 3'd3,
        OP_MOV = 3'd4,
        OP_MVN = 3'd5,
        OP_TST = 3'd6,
        OP_TEQ = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_LSL = 2'd0,
        ST_LSR = 2'd1,
        ST_ASR = 2'd2,
        ST_ROR = 2'd3
    } stype_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    // TST/TEQ only produce flags; every other opcode writes the destination.
    function automatic logic writes_rd(input op_e op);
        return (op != OP_TST) && (op != OP_TEQ);
    endfunction

endpackage

// File: rtl/op_logic_seq_shift_step.sv
// One combinational shifter step: moves the operand by up to STEP bits
// (k of them) and reports the last bit shifted out, or performs RRX.
module logic_shift_step
    import op_logic_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic [WIDTH-1:0]   value,
    input  logic [SHAMT_W-1:0] k,
    input  stype_e             stype,
    input  logic               rrx,
    input  logic               carry,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        result    = value;
        carry_out = carry;
        if (rrx) begin
            result    = {carry, value[WIDTH-1:1]};
            carry_out = value[0];
        end else begin
            // Unrolled single-bit steps; the final iteration's shifted-out bit is the carry.
            for (int i = 0; i < STEP; i++) begin
                if (i < int'(k)) begin
                    unique case (stype)
                        ST_LSL: begin
                            carry_out = result[WIDTH-1];
                            result    = {result[WIDTH-2:0], 1'b0};
                        end
                        ST_LSR: begin
                            carry_out = result[0];
                            result    = {1'b0, result[WIDTH-1:1]};
                        end
                        ST_ASR: begin
                            carry_out = result[0];
                            result    = {result[WIDTH-1], result[WIDTH-1:1]};
                        end
                        ST_ROR: begin
                            carry_out = result[0];
                            result    = {result[0], result[WIDTH-1:1]};
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/op_logic_seq.sv
// Sequential logical-operation unit: latches the request, shifts operand2
// iteratively by up to STEP bits per cycle, then computes result and flags.
module op_logic_seq
    import op_logic_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int IMM_W   = 12,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               ready,
    input  logic               imm_sel,
    input  logic               S,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   Rn,
    input  logic [WIDTH-1:0]   Rm,
    input  logic [IMM_W-1:0]   imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         stype,
    input  logic               carry_in,
    input  logic               zero_in,
    input  logic               neg_in,
    output logic [WIDTH-1:0]   Rd,
    output logic               rd_we,
    output logic               done,
    output logic               carry_out,
    output logic               zero_out,
    output logic               neg_out
);

    state_e             state_q, state_d;
    op_e                op_q;
    stype_e             stype_q;
    logic [WIDTH-1:0]   rn_q, op2_q;
    logic [SHAMT_W-1:0] rem_q, k;
    logic               s_q, rrx_q, sc_q;
    logic               cin_q, zin_q, nin_q;
    logic [WIDTH-1:0]   step_val, res;
    logic               step_c;

    assign ready = (state_q == S_IDLE);

    always_comb begin
        k = (int'(rem_q) < STEP) ? rem_q : SHAMT_W'(STEP);
    end

    logic_shift_step #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) u_step (
        .value     (op2_q),
        .k         (k),
        .stype     (stype_q),
        .rrx       (rrx_q),
        .carry     (sc_q),
        .result    (step_val),
        .carry_out (step_c)
    );

    // NOTE: clocked state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d = (imm_sel || (shamt == '0 && stype != ST_ROR)) ? S_EXEC : S_SHIFT;
            end
            S_SHIFT: if (rem_q == k) state_d = S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res = '0;
        unique case (op_q)
            OP_AND, OP_TST: res = rn_q & op2_q;
            OP_ORR:         res = rn_q | op2_q;
            OP_EOR, OP_TEQ: res = rn_q ^ op2_q;
            OP_BIC:         res = rn_q & ~op2_q;
            OP_MOV:         res = op2_q;
            OP_MVN:         res = ~op2_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= OP_AND;
            stype_q   <= ST_LSL;
            rn_q      <= '0;
            op2_q     <= '0;
            rem_q     <= '0;
            s_q       <= 1'b0;
            rrx_q     <= 1'b0;
            sc_q      <= 1'b0;
            cin_q     <= 1'b0;
            zin_q     <= 1'b0;
            nin_q     <= 1'b0;
            Rd        <= '0;
            rd_we     <= 1'b0;
            done      <= 1'b0;
            carry_out <= 1'b0;
            zero_out  <= 1'b0;
            neg_out   <= 1'b0;
        end else begin
            done  <= 1'b0;
            rd_we <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    op_q    <= op_e'(op);
                    stype_q <= stype_e'(stype);
                    rn_q    <= Rn;
                    op2_q   <= imm_sel ? {{(WIDTH-IMM_W){1'b0}}, imm} : Rm;
                    rem_q   <= (shamt == '0) ? SHAMT_W'(1) : shamt;
                    rrx_q   <= !imm_sel && shamt == '0 && stype == ST_ROR;
                    s_q     <= S;
                    sc_q    <= carry_in;
                    cin_q   <= carry_in;
                    zin_q   <= zero_in;
                    nin_q   <= neg_in;
                end
                S_SHIFT: begin
                    op2_q <= step_val;
                    sc_q  <= step_c;
                    rem_q <= rem_q - k;
                end
                S_EXEC: begin
                    done  <= 1'b1;
                    rd_we <= writes_rd(op_q);
                    if (writes_rd(op_q)) Rd <= res;
                    if (s_q) begin
                        neg_out   <= res[WIDTH-1];
                        zero_out  <= (res == '0);
                        carry_out <= sc_q;
                    end else begin
                        neg_out   <= nin_q;
                        zero_out  <= zin_q;
                        carry_out <= cin_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_op_logic_seq.sv
// Self-checking bench for op_logic_seq: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_op_logic_seq;

    localparam int WIDTH   = 32;
    localparam int IMM_W   = 12;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               ready;
    logic               imm_sel;
    logic               S;
    logic [2:0]         op;
    logic [WIDTH-1:0]   Rn, Rm, Rd;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         stype;
    logic               carry_in, zero_in, neg_in;
    logic               rd_we, done;
    logic               carry_out, zero_out, neg_out;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] model_rd = '0;

    op_logic_seq #(
        .WIDTH(WIDTH), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W), .STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .imm_sel(imm_sel), .S(S), .op(op), .Rn(Rn), .Rm(Rm), .imm(imm),
        .shamt(shamt), .stype(stype),
        .carry_in(carry_in), .zero_in(zero_in), .neg_in(neg_in),
        .Rd(Rd), .rd_we(rd_we), .done(done),
        .carry_out(carry_out), .zero_out(zero_out), .neg_out(neg_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Architectural view: shift Rm by the whole amount at once, then apply the logic op.
    function automatic void ref_op(
        input  logic [2:0]  op_i,
        input  logic        imm_sel_i,
        input  logic        s_i,
        input  logic [31:0] rn,
        input  logic [31:0] rm,
        input  logic [11:0] imm_i,
        input  logic [4:0]  shamt_i,
        input  logic [1:0]  stype_i,
        input  logic        cin, zin, nin,
        output logic [31:0] res,
        output logic [2:0]  flags,
        output int          lat
    );
        logic [31:0] op2;
        logic        sc;
        int          sh;
        sh  = int'(shamt_i);
        sc  = cin;
        op2 = rm;
        if (imm_sel_i) begin
            op2 = {20'd0, imm_i};
            lat = 1;
        end else if (sh == 0 && stype_i != 2'd3) begin
            lat = 1;
        end else if (sh == 0) begin
            op2 = {cin, rm[31:1]};
            sc  = rm[0];
            lat = 2;
        end else begin
            lat = 1 + (sh + STEP - 1) / STEP;
            case (stype_i)
                2'd0: begin op2 = rm << sh;                      sc = rm[32-sh]; end
                2'd1: begin op2 = rm >> sh;                      sc = rm[sh-1];  end
                2'd2: begin op2 = $signed(rm) >>> sh;            sc = rm[sh-1];  end
                default: begin op2 = (rm >> sh) | (rm << (32-sh)); sc = rm[sh-1]; end
            endcase
        end
        case (op_i)
            3'd0, 3'd6: res = rn & op2;
            3'd1:       res = rn | op2;
            3'd2, 3'd7: res = rn ^ op2;
            3'd3:       res = rn & ~op2;
            3'd4:       res = op2;
            default:    res = ~op2;
        endcase
        if (s_i) flags = {sc, res == 32'd0, res[31]};
        else     flags = {cin, zin, nin};
    endfunction

    task automatic run_op(
        input logic [2:0]  op_i,
        input logic        imm_sel_i,
        input logic        s_i,
        input logic [31:0] rn,
        input logic [31:0] rm,
        input logic [11:0] imm_i,
        input logic [4:0]  shamt_i,
        input logic [1:0]  stype_i,
        input logic        cin, zin, nin,
        input bit          probe
    );
        logic [31:0] exp_res;
        logic [2:0]  exp_flags;
        int          lat;
        int          seen;
        ref_op(op_i, imm_sel_i, s_i, rn, rm, imm_i, shamt_i, stype_i, cin, zin, nin,
               exp_res, exp_flags, lat);
        @(negedge clk);
        op = op_i; imm_sel = imm_sel_i; S = s_i; Rn = rn; Rm = rm; imm = imm_i;
        shamt = shamt_i; stype = stype_i; carry_in = cin; zero_in = zin; neg_in = nin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            if (probe && c == 1) begin
                check("busy_ready", 32'(ready), 32'd0);
                start = 1'b1; Rn = $urandom; Rm = $urandom; op = 3'(($urandom % 6));
            end
            if (probe && c == 2) start = 1'b0;
            if (done) begin
                seen = c;
                break;
            end
        end
        start = 1'b0;
        check("latency", 32'(seen), 32'(lat));
        if (op_i < 3'd6) model_rd = exp_res;
        check("rd", Rd, model_rd);
        check("rd_we", 32'(rd_we), 32'(op_i < 3'd6));
        check("flags_czn", 32'({carry_out, zero_out, neg_out}), 32'(exp_flags));
        check("ready_done", 32'(ready), 32'd1);
        if (probe) begin
            @(posedge clk);
            #1 check("no_queue", 32'(done), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; imm_sel = 1'b0; S = 1'b0; op = '0;
        Rn = '0; Rm = '0; imm = '0; shamt = '0; stype = '0;
        carry_in = 1'b0; zero_in = 1'b0; neg_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", Rd, 32'd0);
        check("rst_done", 32'({done, rd_we}), 32'd0);
        check("rst_flags", 32'({carry_out, zero_out, neg_out}), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        @(negedge clk) rst = 1'b0;

        // Directed cases.
        run_op(3'd1, 1, 1, 32'h0000F000, 32'h0, 12'h0FF, 5'd0, 2'd0, 1, 0, 0, 0);
        run_op(3'd0, 0, 1, 32'hFFFFFFFF, 32'h00800001, 12'h0, 5'd9, 2'd0, 0, 0, 0, 1);
        run_op(3'd4, 0, 1, 32'h0, 32'h80000000, 12'h0, 5'd4, 2'd2, 1, 0, 0, 0);
        run_op(3'd4, 0, 1, 32'h0, 32'h00000001, 12'h0, 5'd0, 2'd3, 1, 0, 0, 0);
        run_op(3'd6, 0, 1, 32'h000000F0, 32'h0000000F, 12'h0, 5'd0, 2'd0, 0, 0, 0, 0);
        run_op(3'd6, 0, 0, 32'h000000F0, 32'h0000000F, 12'h0, 5'd0, 2'd0, 1, 0, 1, 0);
        run_op(3'd2, 0, 1, 32'h12345678, 32'h80000001, 12'h0, 5'd31, 2'd0, 0, 1, 1, 0);
        run_op(3'd3, 0, 1, 32'hFFFF0000, 32'hF000000F, 12'h0, 5'd8, 2'd3, 0, 0, 0, 1);

        // Reset in the middle of a ROR 31.
        @(negedge clk);
        op = 3'd4; imm_sel = 1'b0; S = 1'b1; Rm = 32'hA5A5A5A5; shamt = 5'd31; stype = 2'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rd", Rd, 32'd0);
        check("midrst_flags", 32'({carry_out, zero_out, neg_out}), 32'd0);
        check("midrst_ready", 32'(ready), 32'd1);
        model_rd = '0;
        @(negedge clk) rst = 1'b0;
        run_op(3'd5, 0, 1, 32'h0, 32'h0000FFFF, 12'h0, 5'd16, 2'd1, 0, 0, 0, 0);

        // Randomized operations, some issued back-to-back in the done cycle.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] sa;
            sa = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom % 32);
            run_op(3'($urandom % 8), ($urandom % 4) == 0, 1'($urandom), $urandom, $urandom,
                   12'($urandom), sa, 2'($urandom % 4),
                   1'($urandom), 1'($urandom), 1'($urandom), 0);
            repeat ($urandom % 2) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
